// File: rtl/agc_ctrl_pkg.sv
// agc_ctrl_pkg: shared encodings for the RX AGC loop.
// Latency: n/a (types only).
// Backpressure: n/a.
package agc_ctrl_pkg;

  // Loop controller states.
  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    SETTLE   = 2'd1,
    EVAL     = 2'd2
  } agc_state_e;

  // Per-evaluation gain decision, listed in priority order.
  typedef enum logic [1:0] {
    DEC_CLIP = 2'd0,  // clip rate too high: large back-off
    DEC_DOWN = 2'd1,  // level above dead band: one step down
    DEC_UP   = 2'd2,  // level below dead band: one step up
    DEC_HOLD = 2'd3   // level inside dead band
  } agc_dec_e;

endpackage : agc_ctrl_pkg

// File: rtl/agc_ctrl_if.sv
// agc_ctrl_if: level measurements, loop configuration and gain outputs of the AGC.
// Latency: n/a (wires only).
// Backpressure: none; level inputs are sampled, gain_stb is a fire-and-forget pulse.
//   master: RX front end / register block (drives measurements and config)
//   slave : agc_ctrl (drives gain, gain_stb, locked)
interface agc_ctrl_if #(
  parameter int GAIN_W = 5
);
  logic              enable;
  logic [GAIN_W-1:0] manual_gain;
  logic [15:0]       rssi;
  logic [15:0]       over_count;
  logic [15:0]       target;
  logic [15:0]       hyst;
  logic [15:0]       over_thresh;
  logic [15:0]       settle_cycles;
  logic [GAIN_W-1:0] gain;
  logic              gain_stb;
  logic              locked;

  modport master (
    output enable, manual_gain, rssi, over_count, target, hyst, over_thresh, settle_cycles,
    input  gain, gain_stb, locked
  );

  modport slave (
    input  enable, manual_gain, rssi, over_count, target, hyst, over_thresh, settle_cycles,
    output gain, gain_stb, locked
  );
endinterface : agc_ctrl_if

// File: rtl/agc_ctrl_decide.sv
// agc_decide: classifies the current level/clip measurement into a gain decision.
// Latency: combinational (0 cycles).
// Backpressure: none.
//   in : rssi, over_count, target, hyst, over_thresh
//   out: dec (DEC_CLIP > DEC_DOWN > DEC_UP > DEC_HOLD priority)
module agc_decide
  import agc_ctrl_pkg::*;
(
  input  logic [15:0] rssi,
  input  logic [15:0] over_count,
  input  logic [15:0] target,
  input  logic [15:0] hyst,
  input  logic [15:0] over_thresh,
  output agc_dec_e    dec
);

  logic [16:0] hi_wide;
  logic [16:0] lo_wide;
  logic [15:0] hi;
  logic [15:0] lo;

  // Dead-band edges are clamped to the 16-bit range instead of wrapping, so a
  // target near either rail still yields a sensible band.
  always_comb begin
    hi_wide = {1'b0, target} + {1'b0, hyst};
    lo_wide = {1'b0, target} - {1'b0, hyst};
    hi      = hi_wide[16] ? 16'hFFFF : hi_wide[15:0];
    lo      = lo_wide[16] ? 16'h0000 : lo_wide[15:0];
  end

  // rssi exactly on hi or lo counts as inside the dead band.
  always_comb begin
    dec = DEC_HOLD;
    if (over_count > over_thresh) begin
      dec = DEC_CLIP;
    end else if (rssi > hi) begin
      dec = DEC_DOWN;
    end else if (rssi < lo) begin
      dec = DEC_UP;
    end
  end

endmodule : agc_decide

// File: rtl/agc_ctrl.sv
// agc_ctrl: closed-loop RX PGA gain controller (settle / evaluate loop, manual bypass).
// Latency: gain updates one cycle after each EVAL; loop period is settle_cycles+2.
// Backpressure: none; gain_stb is a one-cycle pulse the gain writer must accept.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : enable/manual_gain, level inputs, thresholds -> gain, gain_stb, locked
module agc_ctrl
  import agc_ctrl_pkg::*;
#(
  parameter int GAIN_W    = 5,
  parameter int GAIN_MAX  = 20,
  parameter int GAIN_INIT = 0,
  parameter int BIG_STEP  = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  agc_ctrl_if.slave bus
);

  localparam logic [GAIN_W-1:0] GMAX  = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] GINIT = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0] GBIG  = GAIN_W'(BIG_STEP);

  agc_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              gain_stb_q, gain_stb_d;
  logic              locked_q, locked_d;
  logic [GAIN_W-1:0] manual_clamped;
  logic [GAIN_W-1:0] gain_next;
  agc_dec_e          dec;

  agc_decide u_decide (
    .rssi        (bus.rssi),
    .over_count  (bus.over_count),
    .target      (bus.target),
    .hyst        (bus.hyst),
    .over_thresh (bus.over_thresh),
    .dec         (dec)
  );

  assign manual_clamped = (bus.manual_gain > GMAX) ? GMAX : bus.manual_gain;

  // Saturating gain step for the current decision.
  always_comb begin
    gain_next = gain_q;
    case (dec)
      DEC_CLIP: gain_next = (gain_q < GBIG) ? '0 : gain_q - GBIG;
      DEC_DOWN: gain_next = (gain_q == '0) ? '0 : gain_q - 1'b1;
      DEC_UP:   gain_next = (gain_q >= GMAX) ? GMAX : gain_q + 1'b1;
      default:  gain_next = gain_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gain_d     = gain_q;
    gain_stb_d = 1'b0;
    locked_d   = locked_q;

    if (!bus.enable) begin
      // Manual override wins from any state; a pending decision is dropped.
      state_d  = DISABLED;
      gain_d   = manual_clamped;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        DISABLED: begin
          gain_d   = manual_clamped;
          locked_d = 1'b0;
          state_d  = SETTLE;
          cnt_d    = bus.settle_cycles;
        end
        SETTLE: begin
          if (cnt_q == 16'd0) begin
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        EVAL: begin
          gain_d     = gain_next;
          gain_stb_d = (gain_next != gain_q);
          locked_d   = (dec == DEC_HOLD);
          state_d    = SETTLE;
          cnt_d      = bus.settle_cycles;
        end
        default: begin
          state_d = DISABLED;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= DISABLED;
      cnt_q      <= 16'd0;
      gain_q     <= GINIT;
      gain_stb_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gain_q     <= gain_d;
      gain_stb_q <= gain_stb_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.gain     = gain_q;
  assign bus.gain_stb = gain_stb_q;
  assign bus.locked   = locked_q;

endmodule : agc_ctrl

// File: tb/tb_agc_ctrl.sv
// tb_agc_ctrl: directed bench for agc_ctrl (reset, ramp, clip, dead band, rails, override).
// Latency: n/a.
// Backpressure: n/a.
module tb_agc_ctrl;

  logic clock;
  logic reset_n;
  int   passed;
  int   total;

  agc_ctrl_if #(.GAIN_W(5)) bus ();

  agc_ctrl #(
    .GAIN_W    (5),
    .GAIN_MAX  (20),
    .GAIN_INIT (0),
    .BIG_STEP  (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Advance n cycles; gain_stb must stay low except possibly on the last cycle,
  // where gain and gain_stb are compared to the expected values.
  task automatic wait_eval(input string tag, input int n, input int exp_gain, input bit exp_stb);
    for (int i = 0; i < n - 1; i++) begin
      step(1);
      check({tag, "_stb_idle"}, 32'(bus.gain_stb), 32'd0);
    end
    step(1);
    check({tag, "_gain"}, 32'(bus.gain), 32'(exp_gain));
    check({tag, "_stb"}, 32'(bus.gain_stb), 32'(exp_stb));
  endtask

  initial begin
    passed = 0;
    total  = 0;

    reset_n           = 1'b0;
    bus.enable        = 1'b0;
    bus.manual_gain   = 5'd0;
    bus.rssi          = 16'd0;
    bus.over_count    = 16'd0;
    bus.target        = 16'd1000;
    bus.hyst          = 16'd50;
    bus.over_thresh   = 16'h8000;
    bus.settle_cycles = 16'd3;

    step(2);
    check("rst_gain", 32'(bus.gain), 32'd0);
    check("rst_stb", 32'(bus.gain_stb), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    reset_n = 1'b1;

    // ---- asynchronous reset mid-SETTLE with gain = 7 (rssi in dead band)
    bus.manual_gain = 5'd7;
    bus.rssi        = 16'd1000;
    step(1);
    check("man7_gain", 32'(bus.gain), 32'd7);
    bus.enable = 1'b1;
    step(7);  // through one hold evaluation, now in SETTLE
    check("pre_rst_gain", 32'(bus.gain), 32'd7);
    check("pre_rst_locked", 32'(bus.locked), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_gain", 32'(bus.gain), 32'd0);
    check("arst_stb", 32'(bus.gain_stb), 32'd0);
    check("arst_locked", 32'(bus.locked), 32'd0);
    bus.enable      = 1'b0;
    bus.manual_gain = 5'd0;
    #1;
    reset_n = 1'b1;
    step(1);

    // ---- ramp up from 0 to GAIN_MAX, one strobe per 5 cycles
    bus.rssi   = 16'd100;
    bus.enable = 1'b1;
    wait_eval("ramp1", 6, 1, 1'b1);
    for (int k = 2; k <= 20; k++) begin
      wait_eval("ramp", 5, k, 1'b1);
    end
    check("ramp_locked", 32'(bus.locked), 32'd0);
    wait_eval("ramp_sat1", 5, 20, 1'b0);
    wait_eval("ramp_sat2", 5, 20, 1'b0);
    check("ramp_sat_locked", 32'(bus.locked), 32'd0);

    // ---- clip back-off from 6: 6 -> 2 -> 0 -> 0
    bus.enable      = 1'b0;
    bus.manual_gain = 5'd6;
    step(1);
    check("clip_man_gain", 32'(bus.gain), 32'd6);
    bus.over_count = 16'h9000;
    bus.rssi       = 16'd2000;
    bus.enable     = 1'b1;
    wait_eval("clip1", 6, 2, 1'b1);
    wait_eval("clip2", 5, 0, 1'b1);
    wait_eval("clip3", 5, 0, 1'b0);

    // ---- dead band edges
    bus.enable      = 1'b0;
    bus.manual_gain = 5'd10;
    bus.over_count  = 16'd0;
    bus.rssi        = 16'd1050;
    step(1);
    bus.enable = 1'b1;
    wait_eval("db_hi", 6, 10, 1'b0);
    check("db_hi_locked", 32'(bus.locked), 32'd1);
    bus.rssi = 16'd950;
    wait_eval("db_lo", 5, 10, 1'b0);
    check("db_lo_locked", 32'(bus.locked), 32'd1);
    bus.rssi = 16'd1051;
    wait_eval("db_over", 5, 9, 1'b1);
    check("db_over_locked", 32'(bus.locked), 32'd0);
    bus.rssi = 16'd949;
    wait_eval("db_under", 5, 10, 1'b1);
    check("db_under_locked", 32'(bus.locked), 32'd0);

    // ---- saturated thresholds: no wrap at either rail
    bus.target = 16'hFFF0;
    bus.hyst   = 16'h0020;
    bus.rssi   = 16'hFFFF;
    wait_eval("sat_hi", 5, 10, 1'b0);
    check("sat_hi_locked", 32'(bus.locked), 32'd1);
    bus.target = 16'd1000;
    bus.rssi   = 16'd0;
    wait_eval("sat_mid", 5, 11, 1'b1);
    check("sat_mid_locked", 32'(bus.locked), 32'd0);
    bus.target = 16'h0010;
    wait_eval("sat_lo", 5, 11, 1'b0);
    check("sat_lo_locked", 32'(bus.locked), 32'd1);

    // ---- manual override during SETTLE, clamped to GAIN_MAX
    step(1);
    bus.enable      = 1'b0;
    bus.manual_gain = 5'd25;
    step(1);
    check("ovr_gain", 32'(bus.gain), 32'd20);
    check("ovr_stb", 32'(bus.gain_stb), 32'd0);
    check("ovr_locked", 32'(bus.locked), 32'd0);
    step(1);
    check("ovr_gain2", 32'(bus.gain), 32'd20);

    // ---- re-enable from manual gain 5; first decision settle_cycles+2 after entry
    bus.manual_gain = 5'd5;
    bus.target      = 16'd1000;
    bus.hyst        = 16'd50;
    bus.rssi        = 16'd0;
    step(1);
    check("reen_man_gain", 32'(bus.gain), 32'd5);
    bus.enable = 1'b1;
    wait_eval("reen", 6, 6, 1'b1);

    // ---- settle_cycles = 0: two-cycle loop after the next reload
    bus.settle_cycles = 16'd0;
    wait_eval("s0_a", 5, 7, 1'b1);
    wait_eval("s0_b", 2, 8, 1'b1);
    wait_eval("s0_c", 2, 9, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_agc_ctrl

// File: doc/agc_ctrl.md
Name:
agc_ctrl

Overview:
Closed-loop RX automatic gain control. Consumes the RX front-end level measurements (`rssi`, `over_count`) and drives the codec RX PGA gain code. It steps gain toward a programmable target level. It backs off hard on ADC clipping and waits a settle interval after every change so the level filter can re-converge. Sits beside the per-channel level meter in the RX path; `gain` goes to the codec serial-interface gain writer.

Parameters:
GAIN_W, 5, width of gain code
GAIN_MAX, 20, highest legal gain code
GAIN_INIT, 0, gain code after reset
BIG_STEP, 4, gain decrement applied on clipping

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = closed-loop AGC, 0 = manual gain
manual_gain  in  GAIN_W  gain code used while enable=0
rssi  in  16  filtered absolute ADC level
over_count  in  16  filtered ADC clip rate
target  in  16  desired rssi level
hyst  in  16  half-width of the dead band around target
over_thresh  in  16  clip-rate threshold
settle_cycles  in  16  wait after each evaluation
gain  out  GAIN_W  PGA gain code
gain_stb  out  1  one-cycle pulse when gain changes in AGC mode
locked  out  1  level inside dead band at last evaluation

Behaviour:
- Clock and reset: one clock domain. reset_n asynchronous, active-low.
- Reset values: `gain`=GAIN_INIT, `gain_stb`=0, `locked`=0, `state`=DISABLED, settle counter=0.
- States: DISABLED, SETTLE, EVAL.
- DISABLED:
  - `gain` <= min(`manual_gain`, GAIN_MAX) every cycle; `locked`=0; `gain_stb`=0.
  - `enable`=1 -> SETTLE, counter loaded with `settle_cycles`.
- SETTLE:
  - Counter decrements each cycle.
  - When counter==0 -> EVAL next cycle.
  - SETTLE therefore lasts `settle_cycles`+1 cycles; `settle_cycles`=0 gives 1 cycle.
- EVAL (exactly 1 cycle); decision uses `rssi`/`over_count` sampled that cycle, priority order:
  1. `over_count` > `over_thresh`: `gain` <= `gain`-BIG_STEP, saturating at 0.
  2. else `rssi` > hi: `gain` <= `gain`-1, saturating at 0.
  3. else `rssi` < lo: `gain` <= `gain`+1, saturating at GAIN_MAX.
  4. else: no change.
  - hi = min(`target`+`hyst`, 0xFFFF); lo = max(`target`-`hyst`, 0). Compute with a 17-bit intermediate; no wrap.
  - The rssi == hi and rssi == lo boundaries fall in the dead band.
  - Then -> SETTLE, counter reloaded.
- gain_stb: asserted in the same cycle the new `gain` value first appears, i.e. the cycle after EVAL. Only when the value actually changed; saturation with no change gives no strobe.
- locked: updated at the end of each EVAL. 1 if case 4, else 0. Held through SETTLE.
- Loop period: `settle_cycles`+2 cycles per evaluation.
- enable deasserted in any state: next cycle is DISABLED. `gain` follows `manual_gain` from that cycle on; any pending decision is discarded.
- Re-enable: loop starts from the current (manual) gain. No strobe on entry.
- reset_n mid-operation: all outputs take reset values immediately, independent of clock.
- All registered outputs; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding (DISABLED/SETTLE/EVAL) and the decision encoding (DEC_CLIP, DEC_DOWN, DEC_UP, DEC_HOLD).
- Sub-module `agc_decide`: combinational comparator block producing the decision code from `rssi`, `over_count`, `target`, `hyst`, `over_thresh`, including the saturated hi/lo computation.
- FSM, counter and saturating gain register stay in `agc_ctrl`.

Test Plan:
- Reset: assert reset_n=0 mid-SETTLE with gain=7 -> gain=GAIN_INIT(0), gain_stb=0, locked=0 immediately, without a clock edge.
- Ramp up: enable=1, settle_cycles=3, rssi=100, target=1000, hyst=50, over_count=0 -> gain 0->1->2..., one gain_stb every 5 cycles; stops at 20 with no further strobes; locked stays 0.
- Clip back-off: gain=6, over_count=0x9000, over_thresh=0x8000, rssi=2000 (above hi) -> gain 6->2->0 (clip priority, saturate). Strobe on both changes, none at the third evaluation.
- Dead band: target=1000, hyst=50, rssi=1050 then 950 -> no gain change, locked=1. rssi=1051 -> gain-1, locked=0.
- Saturated thresholds: target=0xFFF0, hyst=0x20, rssi=0xFFFF -> hold, locked=1 (no wrap). target=0x10, hyst=0x20, rssi=0 -> hold.
- Manual override: enable 1->0 during SETTLE with manual_gain=25 -> next cycle DISABLED, gain=20 (clamped), no gain_stb. Re-enable -> first evaluation `settle_cycles`+2 cycles later.
